// File: rtl/mul_stage_pkg.sv
// Shared geometry and control/data types for the PE multiply stage.
// Holds the PE configuration (widths, row count) and the pipe control structs.
package mul_stage_pkg;

    // PE geometry
    localparam int DWD     = 16;
    localparam int PSUMDWD = 32;
    localparam int PEROW   = 4;

    typedef enum logic [1:0] {
        MODE_XNOR = 2'd0,
        MODE_D4   = 2'd1,
        MODE_D8   = 2'd2,
        MODE_D16  = 2'd3
    } mode_e;

    // D16 runs the 8-bit array twice: low weight byte first, then high byte.
    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } phase_e;

    typedef struct packed {
        mode_e mode;
    } MSctl;

    typedef logic [3:0] SSctl;
    typedef logic [3:0] SSppctl;

    typedef struct packed {
        MSctl   msctl;
        SSctl   ssctl;
        SSppctl ssppctl;
    } MSpipein;

    typedef struct packed {
        SSctl   ssctl;
        SSppctl ssppctl;
    } MSpipeout;

    typedef struct packed {
        logic [DWD-1:0]     Input_FS;
        logic [DWD-1:0]     Weight_FS;
        logic [PSUMDWD-1:0] Psum_FS;
    } MSin;

    typedef struct packed {
        logic [PSUMDWD-1:0] Prod_MS;
        logic [PSUMDWD-1:0] Psum_MS;
    } MSout;

    function automatic MSpipeout to_pipeout(input MSpipein p);
        MSpipeout o;
        o.ssctl   = p.ssctl;
        o.ssppctl = p.ssppctl;
        return o;
    endfunction

endpackage

// File: rtl/mul_stage_lane.sv
// Per-row combinational packed multiplier: XNOR, dual/quad narrow dot products,
// or one half (selected by phase_i) of a 16-bit signed multiply.
module mul_lane
    import mul_stage_pkg::*;
(
    input  mode_e              mode_i,
    input  phase_e             phase_i,
    input  logic [DWD-1:0]     a_i,
    input  logic [DWD-1:0]     w_i,
    output logic [PSUMDWD-1:0] part_o
);

    localparam int PW = DWD + 9;

    logic [DWD-1:0]            xn;
    logic signed [7:0]         p4;
    logic signed [15:0]        p8;
    logic signed [PW-1:0]      p16;
    logic signed [PSUMDWD-1:0] acc;

    always_comb begin
        xn  = ~(a_i ^ w_i);
        p4  = '0;
        p8  = '0;
        p16 = '0;
        acc = '0;
        unique case (mode_i)
            MODE_XNOR: begin
                for (int i = 0; i < DWD; i++) acc = acc + PSUMDWD'(xn[i]);
                acc = (acc <<< 1) - PSUMDWD'(DWD);
            end
            MODE_D4: begin
                for (int i = 0; i < DWD / 4; i++) begin
                    p4  = 8'($signed(a_i[4*i +: 4])) * 8'($signed(w_i[4*i +: 4]));
                    acc = acc + PSUMDWD'(p4);
                end
            end
            MODE_D8: begin
                for (int i = 0; i < DWD / 8; i++) begin
                    p8  = 16'($signed(a_i[8*i +: 8])) * 16'($signed(w_i[8*i +: 8]));
                    acc = acc + PSUMDWD'(p8);
                end
            end
            MODE_D16: begin
                // Low byte of the weight is a magnitude; only the high byte carries sign.
                if (phase_i == PH_LO)
                    p16 = PW'($signed(a_i)) * PW'($signed({1'b0, w_i[7:0]}));
                else
                    p16 = PW'($signed(a_i)) * PW'($signed(w_i[DWD-1:8]));
                acc = PSUMDWD'(p16);
            end
        endcase
        part_o = acc;
    end

endmodule

// File: rtl/mul_stage.sv
// PE multiply stage: per-row packed multiply registered toward the sum stage,
// with a two-phase D16 path. MS_ZERO_SKIP_EN lets all-zero D16 ops finish in one cycle.
module mul_stage
    import mul_stage_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rstn,
    input  MSpipein             i_pipe,
    input  logic                FS_rdy,
    output logic                FS_ack,
    output logic                MS_rdy,
    input  logic                MS_ack,
    input  MSin  [PEROW-1:0]    i_data,
    output MSout [PEROW-1:0]    o_data,
    output MSpipeout            o_MSpipe_MS
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HI16 = 1'b1
    } state_e;

    state_e                        state_q, state_d;
    logic                          rdy_q, rdy_d;
    MSout [PEROW-1:0]              out_q, out_d;
    MSpipeout                      pipe_q, pipe_d;
    logic [PEROW-1:0][DWD-1:0]     a_q, a_d, w_q, w_d;
    logic [PEROW-1:0][PSUMDWD-1:0] psum_q, psum_d, lo_q, lo_d;
    MSpipeout                      hpipe_q, hpipe_d;

    logic [PEROW-1:0][DWD-1:0]     lane_a, lane_w;
    logic [PEROW-1:0][PSUMDWD-1:0] lane_p;
    mode_e                         lane_mode;
    phase_e                        lane_phase;
    logic                          out_free, is_d16, skip;

    assign out_free = !rdy_q || MS_ack;
    assign FS_ack   = FS_rdy && (state_q == ST_IDLE) && out_free;
    assign is_d16   = (i_pipe.msctl.mode == MODE_D16);

`ifdef MS_ZERO_SKIP_EN
    logic [PEROW-1:0] row_zero;
    for (genvar r = 0; r < PEROW; r++) begin : g_zero
        assign row_zero[r] = (i_data[r].Input_FS == '0) || (i_data[r].Weight_FS == '0);
    end
    assign skip = &row_zero;
`else
    assign skip = 1'b0;
`endif

    // HI16 feeds the lanes from the latched operands; otherwise straight from fetch.
    always_comb begin
        lane_mode  = i_pipe.msctl.mode;
        lane_phase = PH_LO;
        for (int r = 0; r < PEROW; r++) begin
            lane_a[r] = i_data[r].Input_FS;
            lane_w[r] = i_data[r].Weight_FS;
        end
        if (state_q == ST_HI16) begin
            lane_mode  = MODE_D16;
            lane_phase = PH_HI;
            lane_a     = a_q;
            lane_w     = w_q;
        end
    end

    for (genvar r = 0; r < PEROW; r++) begin : g_lane
        mul_lane u_lane (
            .mode_i  (lane_mode),
            .phase_i (lane_phase),
            .a_i     (lane_a[r]),
            .w_i     (lane_w[r]),
            .part_o  (lane_p[r])
        );
    end

    always_comb begin
        state_d = state_q;
        rdy_d   = rdy_q;
        out_d   = out_q;
        pipe_d  = pipe_q;
        a_d     = a_q;
        w_d     = w_q;
        psum_d  = psum_q;
        lo_d    = lo_q;
        hpipe_d = hpipe_q;
        if (rdy_q && MS_ack) rdy_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (FS_ack) begin
                    if (is_d16 && !skip) begin
                        state_d = ST_HI16;
                        lo_d    = lane_p;
                        hpipe_d = to_pipeout(i_pipe);
                        for (int r = 0; r < PEROW; r++) begin
                            a_d[r]    = i_data[r].Input_FS;
                            w_d[r]    = i_data[r].Weight_FS;
                            psum_d[r] = i_data[r].Psum_FS;
                        end
                    end else begin
                        // A skipped D16 has a zero operand per row, so its low partial is already 0.
                        for (int r = 0; r < PEROW; r++) begin
                            out_d[r].Prod_MS = lane_p[r];
                            out_d[r].Psum_MS = i_data[r].Psum_FS;
                        end
                        pipe_d = to_pipeout(i_pipe);
                        rdy_d  = 1'b1;
                    end
                end
            end
            ST_HI16: begin
                if (out_free) begin
                    for (int r = 0; r < PEROW; r++) begin
                        out_d[r].Prod_MS = lo_q[r] + (lane_p[r] << 8);
                        out_d[r].Psum_MS = psum_q[r];
                    end
                    pipe_d  = hpipe_q;
                    rdy_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            out_q   <= '0;
            pipe_q  <= '0;
            a_q     <= '0;
            w_q     <= '0;
            psum_q  <= '0;
            lo_q    <= '0;
            hpipe_q <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            out_q   <= out_d;
            pipe_q  <= pipe_d;
            a_q     <= a_d;
            w_q     <= w_d;
            psum_q  <= psum_d;
            lo_q    <= lo_d;
            hpipe_q <= hpipe_d;
        end
    end

    assign MS_rdy      = rdy_q;
    assign o_data      = out_q;
    assign o_MSpipe_MS = pipe_q;

endmodule

// File: tb/tb_mul_stage.sv
// Directed + randomized bench for mul_stage with an expected-result queue.
module tb_mul_stage;
    import mul_stage_pkg::*;

    typedef struct packed {
        MSout [PEROW-1:0] d;
        MSpipeout         p;
    } exp_t;

`ifdef MS_ZERO_SKIP_EN
    localparam int EXP_ZLAT = 1;
`else
    localparam int EXP_ZLAT = 2;
`endif

    logic             i_clk = 1'b0;
    logic             i_rstn;
    MSpipein          i_pipe;
    logic             FS_rdy, FS_ack, MS_rdy, MS_ack;
    MSin  [PEROW-1:0] i_data;
    MSout [PEROW-1:0] o_data;
    MSpipeout         o_MSpipe_MS;

    int   n_asrt = 0;
    int   n_fail = 0;
    bit   rnd_ack = 1'b0;
    exp_t cur;
    exp_t sb[$];

    mul_stage dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_pipe      (i_pipe),
        .FS_rdy      (FS_rdy),
        .FS_ack      (FS_ack),
        .MS_rdy      (MS_rdy),
        .MS_ack      (MS_ack),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_MSpipe_MS (o_MSpipe_MS)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PSUMDWD-1:0] model(input mode_e m, input logic [DWD-1:0] a,
                                                 input logic [DWD-1:0] w);
        int r;
        logic signed [3:0] x4, y4;
        logic signed [7:0] x8, y8;
        r = 0;
        case (m)
            MODE_XNOR: r = 2 * $countones(~(a ^ w)) - DWD;
            MODE_D4: for (int i = 0; i < DWD / 4; i++) begin
                x4 = a[4*i +: 4];
                y4 = w[4*i +: 4];
                r += int'(x4) * int'(y4);
            end
            MODE_D8: for (int i = 0; i < DWD / 8; i++) begin
                x8 = a[8*i +: 8];
                y8 = w[8*i +: 8];
                r += int'(x8) * int'(y8);
            end
            default: r = int'($signed(a)) * int'($signed(w));
        endcase
        return PSUMDWD'(r);
    endfunction

    // Row 0 gets the directed operands; other rows are random (weights forced 0 when zw).
    task automatic drive(input mode_e m, input logic [DWD-1:0] a0, input logic [DWD-1:0] w0,
                         input bit zw);
        logic [DWD-1:0]     a, w;
        logic [PSUMDWD-1:0] ps;
        i_pipe.msctl.mode = m;
        i_pipe.ssctl      = 4'($urandom);
        i_pipe.ssppctl    = 4'($urandom);
        for (int r = 0; r < PEROW; r++) begin
            a  = (r == 0) ? a0 : DWD'($urandom);
            w  = (r == 0) ? w0 : (zw ? '0 : DWD'($urandom));
            ps = $urandom;
            i_data[r].Input_FS  = a;
            i_data[r].Weight_FS = w;
            i_data[r].Psum_FS   = ps;
            cur.d[r].Prod_MS    = model(m, a, w);
            cur.d[r].Psum_MS    = ps;
        end
        cur.p.ssctl   = i_pipe.ssctl;
        cur.p.ssppctl = i_pipe.ssppctl;
        FS_rdy = 1'b1;
    endtask

    // Returns #1 after the accepting edge; cyc = stalled cycles before acceptance.
    task automatic wait_accept(output int cyc);
        bit ok;
        ok  = 1'b0;
        cyc = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge i_clk);
            if (FS_ack) begin
                ok = 1'b1;
                sb.push_back(cur);
            end else begin
                cyc++;
                @(posedge i_clk); #1;
                if (rnd_ack) MS_ack = 1'($urandom_range(0, 1));
            end
        end
        chk("accept_timeout", 64'(ok), 64'd1);
        if (ok) begin
            @(posedge i_clk); #1;
            if (rnd_ack) MS_ack = 1'($urandom_range(0, 1));
        end
    endtask

    // Scoreboard: every output transfer must match the oldest accepted transaction.
    always @(negedge i_clk) begin
        if (i_rstn === 1'b1 && MS_rdy === 1'b1 && MS_ack === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", 64'(sb.size()), 64'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                for (int r = 0; r < PEROW; r++) begin
                    chk($sformatf("sb_prod_r%0d", r), 64'(o_data[r].Prod_MS), 64'(e.d[r].Prod_MS));
                    chk($sformatf("sb_psum_r%0d", r), 64'(o_data[r].Psum_MS), 64'(e.d[r].Psum_MS));
                end
                chk("sb_pipe", 64'(o_MSpipe_MS), 64'(e.p));
            end
        end
    end

    initial begin
        int       cyc, lat;
        MSpipeout hold;

        i_rstn = 1'b0;
        FS_rdy = 1'b0;
        MS_ack = 1'b0;
        i_pipe = '0;
        i_data = '0;
        repeat (2) @(posedge i_clk);
        #1;
        @(negedge i_clk);
        chk("rst_ms_rdy", 64'(MS_rdy), 64'd0);
        chk("rst_fs_ack", 64'(FS_ack), 64'd0);
        chk("rst_data", 64'(|o_data), 64'd0);
        chk("rst_pipe", 64'(o_MSpipe_MS), 64'd0);
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        MS_ack = 1'b1;

        // D8, latency 1
        drive(MODE_D8, 16'h03FE, 16'h0205, 1'b0);
        wait_accept(cyc);
        FS_rdy = 1'b0;
        @(negedge i_clk);
        chk("d8_rdy", 64'(MS_rdy), 64'd1);
        chk("d8_prod", 64'(o_data[0].Prod_MS), 64'hFFFF_FFFC);
        @(posedge i_clk); #1;

        // D16, FS_ack held low while in the high phase, latency 2
        drive(MODE_D16, 16'h8000, 16'h7FFF, 1'b0);
        wait_accept(cyc);
        @(negedge i_clk);
        chk("d16_fs_ack_low", 64'(FS_ack), 64'd0);
        chk("d16_rdy_c1", 64'(MS_rdy), 64'd0);
        @(posedge i_clk); #1;
        FS_rdy = 1'b0;
        @(negedge i_clk);
        chk("d16_rdy_c2", 64'(MS_rdy), 64'd1);
        chk("d16_prod", 64'(o_data[0].Prod_MS), 64'hC000_8000);
        @(posedge i_clk); #1;

        // Back-to-back narrow ops at one per cycle
        for (int k = 0; k < 4; k++) begin
            drive((k % 2) ? MODE_D4 : MODE_D8, DWD'($urandom), DWD'($urandom), 1'b0);
            wait_accept(cyc);
            chk("b2b_stall", 64'(cyc), 64'd0);
        end
        FS_rdy = 1'b0;
        @(posedge i_clk); #1;

        // Backpressure: XNOR result held 3 cycles, then replaced in the acking cycle
        MS_ack = 1'b0;
        drive(MODE_XNOR, 16'hFFFF, 16'h0000, 1'b0);
        wait_accept(cyc);
        hold = cur.p;
        drive(MODE_XNOR, 16'h1234, 16'h1234, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("bp_fs_ack", 64'(FS_ack), 64'd0);
            chk("bp_rdy", 64'(MS_rdy), 64'd1);
            chk("bp_prod_hold", 64'(o_data[0].Prod_MS), 64'hFFFF_FFF0);
            chk("bp_pipe_hold", 64'(o_MSpipe_MS), 64'(hold));
            @(posedge i_clk); #1;
        end
        MS_ack = 1'b1;
        wait_accept(cyc);
        chk("bp_same_cycle", 64'(cyc), 64'd0);
        FS_rdy = 1'b0;
        @(negedge i_clk);
        chk("xnor_eq_prod", 64'(o_data[0].Prod_MS), 64'h0000_0010);
        @(posedge i_clk); #1;

        // Reset while in the high phase discards the D16 op
        drive(MODE_D16, 16'h7123, 16'h4567, 1'b0);
        wait_accept(cyc);
        i_rstn = 1'b0;
        FS_rdy = 1'b0;
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        sb.delete();
        @(negedge i_clk);
        chk("rstmid_rdy", 64'(MS_rdy), 64'd0);
        chk("rstmid_data", 64'(|o_data), 64'd0);
        chk("rstmid_pipe", 64'(o_MSpipe_MS), 64'd0);
        @(posedge i_clk); #1;
        drive(MODE_D4, 16'h1111, 16'h1111, 1'b0);
        wait_accept(cyc);
        chk("rstmid_idle_accept", 64'(cyc), 64'd0);
        FS_rdy = 1'b0;
        @(negedge i_clk);
        chk("d4_prod", 64'(o_data[0].Prod_MS), 64'd4);
        @(posedge i_clk); #1;

        // D16 with every weight zero: latency depends on zero-skip build
        drive(MODE_D16, 16'h1234, 16'h0000, 1'b1);
        wait_accept(cyc);
        FS_rdy = 1'b0;
        lat = 1;
        @(negedge i_clk);
        while (!MS_rdy && lat < 6) begin
            @(negedge i_clk);
            lat++;
        end
        chk("zero_d16_latency", 64'(lat), 64'(EXP_ZLAT));
        chk("zero_d16_prod", 64'(o_data[0].Prod_MS), 64'd0);
        @(posedge i_clk); #1;

        // Random modes and operands with random sum-stage backpressure
        rnd_ack = 1'b1;
        for (int k = 0; k < 30; k++) begin
            drive(mode_e'($urandom_range(0, 3)), DWD'($urandom), DWD'($urandom), 1'b0);
            wait_accept(cyc);
        end
        FS_rdy  = 1'b0;
        rnd_ack = 1'b0;
        MS_ack  = 1'b1;
        for (int n = 0; n < 20 && sb.size() != 0; n++) @(negedge i_clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
